// File: rtl/ibram_pingpong_sched.sv
// Ping-pong scheduler for the two halves of the input BRAM: hands each half to the
// writer, then to the reader, and counts layers until the configured run completes.
module ibram_pingpong_sched #(
    parameter int WRITE_DEPTH    = 512,
    parameter int MAX_NUM_LAYERS = 16,
    localparam int LW = $clog2(MAX_NUM_LAYERS) + 1,
    localparam int WW = $clog2(WRITE_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [LW-1:0] cfg_num_layers,
    input  logic          wr_req,
    output logic          wr_gnt,
    output logic          wr_sel,
    input  logic          wr_done,
    input  logic [WW-1:0] wr_words,
    input  logic          rd_req,
    output logic          rd_gnt,
    output logic          rd_sel,
    output logic [WW-1:0] rd_words,
    input  logic          rd_done,
    output logic [1:0]    full_cnt,
    output logic          busy,
    output logic          all_done,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} buf_state_t;

    localparam logic [WW-1:0] DEPTH_W = WW'(WRITE_DEPTH);

    state_t        r_state, w_state_nxt;
    buf_state_t    r_buf       [0:1];
    buf_state_t    w_buf_nxt   [0:1];
    logic [WW-1:0] r_words     [0:1];
    logic [WW-1:0] w_words_nxt [0:1];
    logic          r_wr_ptr, w_wr_ptr_nxt;
    logic          r_rd_ptr, w_rd_ptr_nxt;
    logic [LW-1:0] r_num_layers, w_num_layers_nxt;
    logic [LW-1:0] r_layers_wr, w_layers_wr_nxt;
    logic [LW-1:0] r_layers_rd, w_layers_rd_nxt;
    logic          r_wr_gnt, r_rd_gnt;
    logic          r_wr_sel, w_wr_sel_nxt;
    logic          r_rd_sel, w_rd_sel_nxt;
    logic [WW-1:0] r_rd_words, w_rd_words_nxt;
    logic [1:0]    r_full_cnt, w_full_cnt_nxt;
    logic          r_err, w_err_nxt;

    logic          w_wr_take, w_rd_take, w_wr_fin, w_rd_fin, w_words_ovf;
    logic [WW-1:0] w_words_clamped;

    // Grant decisions look only at registered buffer state, so a half freed this
    // cycle becomes grantable on the next one.
    assign w_wr_take = (r_state == S_RUN) && wr_req && (r_buf[r_wr_ptr] == B_EMPTY)
                       && (r_layers_wr < r_num_layers);
    assign w_rd_take = (r_state == S_RUN) && rd_req && (r_buf[r_rd_ptr] == B_FULL);
    assign w_wr_fin  = wr_done && (r_buf[r_wr_ptr] == B_FILL);
    assign w_rd_fin  = rd_done && (r_buf[r_rd_ptr] == B_DRAIN);

    assign w_words_ovf     = wr_words > DEPTH_W;
    assign w_words_clamped = w_words_ovf ? DEPTH_W : wr_words;

    // NOTE: every variable gets its default before any branch, so no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_buf_nxt[0]     = r_buf[0];
        w_buf_nxt[1]     = r_buf[1];
        w_words_nxt[0]   = r_words[0];
        w_words_nxt[1]   = r_words[1];
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_num_layers_nxt = r_num_layers;
        w_layers_wr_nxt  = r_layers_wr;
        w_layers_rd_nxt  = r_layers_rd;
        w_wr_sel_nxt     = r_wr_sel;
        w_rd_sel_nxt     = r_rd_sel;
        w_rd_words_nxt   = r_rd_words;
        w_err_nxt        = r_err;

        // Writer and reader events never target the same half in one cycle: each
        // requires a different source state, so their updates cannot collide.
        if (w_wr_take) begin
            w_buf_nxt[r_wr_ptr] = B_FILL;
            w_wr_sel_nxt        = r_wr_ptr;
        end
        if (w_wr_fin) begin
            w_buf_nxt[r_wr_ptr]   = B_FULL;
            w_words_nxt[r_wr_ptr] = w_words_clamped;
            w_wr_ptr_nxt          = ~r_wr_ptr;
            w_layers_wr_nxt       = r_layers_wr + LW'(1);
            if (w_words_ovf) w_err_nxt = 1'b1;
        end else if (wr_done) begin
            w_err_nxt = 1'b1;
        end

        if (w_rd_take) begin
            w_buf_nxt[r_rd_ptr] = B_DRAIN;
            w_rd_sel_nxt        = r_rd_ptr;
            w_rd_words_nxt      = r_words[r_rd_ptr];
        end
        if (w_rd_fin) begin
            w_buf_nxt[r_rd_ptr] = B_EMPTY;
            w_rd_ptr_nxt        = ~r_rd_ptr;
            w_layers_rd_nxt     = r_layers_rd + LW'(1);
        end else if (rd_done) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_num_layers_nxt = cfg_num_layers;
                    w_layers_wr_nxt  = '0;
                    w_layers_rd_nxt  = '0;
                    w_err_nxt        = 1'b0;
                    w_buf_nxt[0]     = B_EMPTY;
                    w_buf_nxt[1]     = B_EMPTY;
                    w_wr_ptr_nxt     = 1'b0;
                    w_rd_ptr_nxt     = 1'b0;
                    w_state_nxt      = (cfg_num_layers == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cfg_valid) w_err_nxt = 1'b1;
                if (r_layers_rd == r_num_layers) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (cfg_valid) w_err_nxt = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_full_cnt_nxt = 2'(w_buf_nxt[0] == B_FULL) + 2'(w_buf_nxt[1] == B_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            // NOTE: the two per-half arrays are control state, not bulk storage, so they are reset.
            for (int i = 0; i < 2; i++) begin
                r_buf[i]   <= B_EMPTY;
                r_words[i] <= '0;
            end
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_num_layers <= '0;
            r_layers_wr  <= '0;
            r_layers_rd  <= '0;
            r_wr_gnt     <= 1'b0;
            r_rd_gnt     <= 1'b0;
            r_wr_sel     <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_rd_words   <= '0;
            r_full_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            for (int i = 0; i < 2; i++) begin
                r_buf[i]   <= w_buf_nxt[i];
                r_words[i] <= w_words_nxt[i];
            end
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_num_layers <= w_num_layers_nxt;
            r_layers_wr  <= w_layers_wr_nxt;
            r_layers_rd  <= w_layers_rd_nxt;
            r_wr_gnt     <= w_wr_take;
            r_rd_gnt     <= w_rd_take;
            r_wr_sel     <= w_wr_sel_nxt;
            r_rd_sel     <= w_rd_sel_nxt;
            r_rd_words   <= w_rd_words_nxt;
            r_full_cnt   <= w_full_cnt_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign all_done  = (r_state == S_DONE);
    assign wr_gnt    = r_wr_gnt;
    assign rd_gnt    = r_rd_gnt;
    assign wr_sel    = r_wr_sel;
    assign rd_sel    = r_rd_sel;
    assign rd_words  = r_rd_words;
    assign full_cnt  = r_full_cnt;
    assign err       = r_err;

endmodule
